lnrv_ilm_arb: RTL and testbench
===============================

LNRV_ILM_ARB -- requirements
Module: lnrv_ilm_arb

Interface
REQ-001 Parameter P_ADDR_WIDTH, default 16, SHALL set the word-address width of the shared SRAM port.
REQ-002 Parameter P_STARVE_LIMIT, default 4, SHALL set the number of consecutive lost cycles after which port 0 gains priority; legal range 1..15.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be a synchronous, active-low reset.
REQ-005 m0_req_valid / m1_req_valid  input  1 each  SHALL be the request strobes; port 0 is instruction fetch, port 1 is load/store.
REQ-006 mX_req_ready  output  1  SHALL indicate the request is accepted this cycle.
REQ-007 mX_req_we  input  1; mX_req_wem  input  4; mX_req_addr  input  P_ADDR_WIDTH; mX_req_wdata  input  32  SHALL form the access command.
REQ-008 mX_rsp_valid  output  1; mX_rsp_rdata  output  32  SHALL return the completion and its read data.
REQ-009 ram_cs, ram_we  output  1; ram_wem  output  4; ram_addr  output  P_ADDR_WIDTH; ram_wdata  output  32  SHALL drive the single-port SRAM.
REQ-010 ram_rdata  input  32  SHALL be valid exactly one cycle after a ram_cs cycle.

Function
REQ-011 Handshake: a request transfers in a cycle when mX_req_valid and mX_req_ready are both 1.
REQ-012 At most one port SHALL be granted per cycle; mX_req_ready is combinational and is 1 only for the granted port.
REQ-013 Default priority: port 1 wins when both ports are valid.
REQ-014 Priority override: port 0 wins when both ports are valid and starve_cnt == P_STARVE_LIMIT.
REQ-015 A single valid port SHALL always be granted in the same cycle, so there is no idle bubble.
REQ-016 Granted command bits SHALL pass combinationally to ram_we/wem/addr/wdata, with ram_cs = 1.
REQ-017 With no grant: ram_cs = 0, ram_we = 0, ram_wem = 0, ram_addr and ram_wdata held at 0.
REQ-018 A 1-bit owner register and a 1-bit pending register SHALL capture the grant.
REQ-019 The granted port's mX_rsp_valid SHALL pulse for exactly one cycle, the cycle after the grant, for both reads and writes.
REQ-020 mX_rsp_rdata SHALL equal ram_rdata when that port's rsp_valid is 1, and 0 otherwise; for writes the data is don't-care.
REQ-021 Responses SHALL have no backpressure; the requester must accept them.
REQ-022 Throughput SHALL be one access per cycle, with back-to-back grants to either port allowed.
REQ-023 starve_cnt is 4 bits and SHALL increment, saturating at P_STARVE_LIMIT, in each cycle where m0_req_valid = 1 and port 0 is not granted.
REQ-024 starve_cnt SHALL clear in each cycle port 0 is granted, and SHALL hold when m0_req_valid = 0.
REQ-025 A request's command fields SHALL be sampled only in its grant cycle; the requester holds them stable while valid and not ready.
REQ-026 Simultaneous grant to one port and response to the other port in the same cycle SHALL be supported.

Reset
REQ-027 While reset_n = 0 at a rising edge: starve_cnt = 0, pending = 0, owner = 0.
REQ-028 While reset_n = 0: m0/m1_rsp_valid = 0, m0/m1_req_ready = 0, ram_cs = 0, ram_we = 0.
REQ-029 Reset asserted in the cycle after a grant SHALL suppress that grant's rsp_valid; the access is lost and no late response appears after reset release.
REQ-030 The first grant SHALL be possible in the first cycle with reset_n = 1.

Verification
REQ-031 Port 0 only: m0 read addr 0x0010, SRAM word 0x0000_0013 -> m0_req_ready = 1 same cycle, ram_cs = 1, ram_addr = 0x0010; next cycle m0_rsp_valid = 1 with m0_rsp_rdata = 0x0000_0013.
REQ-032 Both valid, starve_cnt = 0: m1 write addr 0x0100, wem = 0x3, wdata 0xDEAD_BEEF -> m1 granted, m0_req_ready = 0, ram_wem = 0x3, starve_cnt = 1; m1_rsp_valid pulses next cycle.
REQ-033 Both ports held valid continuously, P_STARVE_LIMIT = 4 -> m1 granted for 4 cycles, m0 granted on the 5th, starve_cnt = 0 afterward, and the pattern repeats.
REQ-034 Alternating grants m1 read then m0 read back-to-back -> m1_rsp_valid and m0 grant in the same cycle, then m0_rsp_valid; each rdata is routed only to its owner.
REQ-035 m0 read granted, reset_n = 0 the following cycle -> m0_rsp_valid stays 0, ram_cs = 0 during reset; after release, a new m0 read completes normally in 1 cycle.
REQ-036 No requests for 10 cycles -> ram_cs = 0 throughout, both rsp_valid = 0, and starve_cnt holds its value.

Source files
------------

// File: rtl/lnrv_ilm_arb.sv
// Two-port arbiter sharing one single-port SRAM between instruction fetch (port 0)
// and load/store (port 1). Port 1 wins by default; port 0 wins once it has starved.
module lnrv_ilm_arb #(
    parameter int P_ADDR_WIDTH   = 16,
    parameter int P_STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    m0_req_valid,
    output logic                    m0_req_ready,
    input  logic                    m0_req_we,
    input  logic [3:0]              m0_req_wem,
    input  logic [P_ADDR_WIDTH-1:0] m0_req_addr,
    input  logic [31:0]             m0_req_wdata,
    output logic                    m0_rsp_valid,
    output logic [31:0]             m0_rsp_rdata,

    input  logic                    m1_req_valid,
    output logic                    m1_req_ready,
    input  logic                    m1_req_we,
    input  logic [3:0]              m1_req_wem,
    input  logic [P_ADDR_WIDTH-1:0] m1_req_addr,
    input  logic [31:0]             m1_req_wdata,
    output logic                    m1_rsp_valid,
    output logic [31:0]             m1_rsp_rdata,

    output logic                    ram_cs,
    output logic                    ram_we,
    output logic [3:0]              ram_wem,
    output logic [P_ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]             ram_wdata,
    input  logic [31:0]             ram_rdata
);

    localparam logic [3:0] STARVE_LIMIT = 4'(P_STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       owner;
    logic       pending;
    logic       gnt0;
    logic       gnt1;
    logic       starved;

    // Grants are suppressed while reset is held so nothing reaches the SRAM.
    always_comb begin
        starved = (starve_cnt == STARVE_LIMIT);
        gnt0    = reset_n && m0_req_valid && (!m1_req_valid || starved);
        gnt1    = reset_n && m1_req_valid && !gnt0;
    end

    assign m0_req_ready = gnt0;
    assign m1_req_ready = gnt1;

    always_comb begin
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_wem   = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt0) begin
            ram_cs    = 1'b1;
            ram_we    = m0_req_we;
            ram_wem   = m0_req_wem;
            ram_addr  = m0_req_addr;
            ram_wdata = m0_req_wdata;
        end else if (gnt1) begin
            ram_cs    = 1'b1;
            ram_we    = m1_req_we;
            ram_wem   = m1_req_wem;
            ram_addr  = m1_req_addr;
            ram_wdata = m1_req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending    <= 1'b0;
            owner      <= 1'b0;
            starve_cnt <= '0;
        end else begin
            pending <= gnt0 || gnt1;
            if (gnt0 || gnt1)
                owner <= gnt1;
            if (gnt0)
                starve_cnt <= '0;
            else if (m0_req_valid && !starved)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Gating with reset_n drops the response of a grant that is followed by reset.
    always_comb begin
        m0_rsp_valid = reset_n && pending && !owner;
        m1_rsp_valid = reset_n && pending && owner;
        m0_rsp_rdata = m0_rsp_valid ? ram_rdata : 32'd0;
        m1_rsp_rdata = m1_rsp_valid ? ram_rdata : 32'd0;
    end

endmodule

// File: tb/tb_lnrv_ilm_arb.sv
// Directed bench for lnrv_ilm_arb: the stimulus pushes expected responses into a
// scoreboard queue and an independent monitor pops them as responses appear.
module tb_lnrv_ilm_arb;

    logic        clk;
    logic        reset_n;
    logic        m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid;
    logic [3:0]  m0_req_wem;
    logic [15:0] m0_req_addr;
    logic [31:0] m0_req_wdata, m0_rsp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid;
    logic [3:0]  m1_req_wem;
    logic [15:0] m1_req_addr;
    logic [31:0] m1_req_wdata, m1_rsp_rdata;
    logic        ram_cs, ram_we;
    logic [3:0]  ram_wem;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    typedef struct {
        int          port;
        int          due;
        logic        chk;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          fails   = 0;
    int          cyc     = 0;
    logic [31:0] mem [0:1023];

    lnrv_ilm_arb dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_wem(m0_req_wem), .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_wem(m1_req_wem), .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-first SRAM model with per-byte write enables and one-cycle read latency.
    always @(posedge clk) begin
        if (ram_cs) begin
            ram_rdata <= mem[ram_addr[9:0]];
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wem[b])
                        mem[ram_addr[9:0]][b*8 +: 8] = ram_wdata[b*8 +: 8];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic setM0(input logic v, input logic we, input logic [3:0] wem,
                         input logic [15:0] addr, input logic [31:0] wdata);
        m0_req_valid = v; m0_req_we = we; m0_req_wem = wem;
        m0_req_addr = addr; m0_req_wdata = wdata;
    endtask

    task automatic setM1(input logic v, input logic we, input logic [3:0] wem,
                         input logic [15:0] addr, input logic [31:0] wdata);
        m1_req_valid = v; m1_req_we = we; m1_req_wem = wem;
        m1_req_addr = addr; m1_req_wdata = wdata;
    endtask

    // exp_gnt: 0 = no grant, 1 = port 0, 2 = port 1.
    task automatic applyStimulus(input int exp_gnt, input logic push_rsp, input logic [31:0] exp_rdata);
        logic        e_we;
        logic [3:0]  e_wem;
        logic [15:0] e_addr;
        logic [31:0] e_wdata;
        exp_t        e;
        e_we = 1'b0; e_wem = '0; e_addr = '0; e_wdata = '0;
        if (exp_gnt == 1) begin
            e_we = m0_req_we; e_wem = m0_req_wem; e_addr = m0_req_addr; e_wdata = m0_req_wdata;
        end else if (exp_gnt == 2) begin
            e_we = m1_req_we; e_wem = m1_req_wem; e_addr = m1_req_addr; e_wdata = m1_req_wdata;
        end
        @(negedge clk);
        checkOutput("m0_req_ready", {31'd0, m0_req_ready}, {31'd0, exp_gnt == 1});
        checkOutput("m1_req_ready", {31'd0, m1_req_ready}, {31'd0, exp_gnt == 2});
        checkOutput("ram_cs", {31'd0, ram_cs}, {31'd0, exp_gnt != 0});
        checkOutput("ram_we", {31'd0, ram_we}, {31'd0, e_we});
        checkOutput("ram_wem", {28'd0, ram_wem}, {28'd0, e_wem});
        checkOutput("ram_addr", {16'd0, ram_addr}, {16'd0, e_addr});
        checkOutput("ram_wdata", ram_wdata, e_wdata);
        if (exp_gnt != 0 && push_rsp) begin
            e.port  = exp_gnt - 1;
            e.due   = cyc + 1;
            e.chk   = !e_we;
            e.rdata = exp_rdata;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response must match the head of the scoreboard in port, cycle and data.
    always @(negedge clk) begin
        logic        v [2];
        logic [31:0] d [2];
        exp_t        e;
        v[0] = m0_rsp_valid; v[1] = m1_rsp_valid;
        d[0] = m0_rsp_rdata; d[1] = m1_rsp_rdata;
        for (int p = 0; p < 2; p++) begin
            if (v[p] === 1'b1) begin
                if (sb.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("[TB] FAIL unexpected_rsp: port %0d rsp_valid=1, expected none (cycle %0d)", p, cyc);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rsp_port", p, e.port);
                    checkOutput("rsp_cycle", cyc, e.due);
                    if (e.chk)
                        checkOutput("rsp_rdata", d[p], e.rdata);
                end
            end else begin
                checkOutput("rsp_valid_low", {31'd0, v[p]}, 32'd0);
                checkOutput("rsp_rdata_zero", d[p], 32'd0);
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[10'h010] = 32'h0000_0013;
        mem[10'h020] = 32'hA5A5_0020;
        mem[10'h030] = 32'h3030_3030;
        mem[10'h100] = 32'h1111_2222;
        ram_rdata = 32'd0;
        reset_n   = 1'b0;
        setM0(1'b1, 1'b0, 4'h0, 16'h0010, 32'd0);
        setM1(1'b1, 1'b1, 4'hF, 16'h0020, 32'h0000_0001);

        // Requests during reset must not be granted.
        repeat (2) applyStimulus(0, 1'b0, 32'd0);

        // First cycle out of reset: port 0 alone, read of 0x0010.
        reset_n = 1'b1;
        setM1(1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);
        applyStimulus(1, 1'b1, 32'h0000_0013);
        setM0(1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);
        applyStimulus(0, 1'b0, 32'd0);

        // Contention with an empty starve counter: load/store write wins.
        setM0(1'b1, 1'b0, 4'h0, 16'h0020, 32'd0);
        setM1(1'b1, 1'b1, 4'h3, 16'h0100, 32'hDEAD_BEEF);
        applyStimulus(2, 1'b1, 32'd0);
        setM1(1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);
        applyStimulus(1, 1'b1, 32'hA5A5_0020);

        // Continuous contention: four port-1 grants then one port-0 grant, twice.
        setM0(1'b1, 1'b0, 4'h0, 16'h0030, 32'd0);
        setM1(1'b1, 1'b0, 4'h0, 16'h0100, 32'd0);
        repeat (2) begin
            repeat (4) applyStimulus(2, 1'b1, 32'h1111_BEEF);
            applyStimulus(1, 1'b1, 32'h3030_3030);
        end

        // Back-to-back port 1 then port 0 reads.
        setM0(1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);
        setM1(1'b1, 1'b0, 4'h0, 16'h0010, 32'd0);
        applyStimulus(2, 1'b1, 32'h0000_0013);
        setM1(1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);
        setM0(1'b1, 1'b0, 4'h0, 16'h0020, 32'd0);
        applyStimulus(1, 1'b1, 32'hA5A5_0020);
        setM0(1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);
        applyStimulus(0, 1'b0, 32'd0);

        // Build starve count to 3, idle 10 cycles, and confirm the count was held.
        setM0(1'b1, 1'b0, 4'h0, 16'h0010, 32'd0);
        setM1(1'b1, 1'b0, 4'h0, 16'h0030, 32'd0);
        repeat (3) applyStimulus(2, 1'b1, 32'h3030_3030);
        setM0(1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);
        setM1(1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);
        repeat (10) applyStimulus(0, 1'b0, 32'd0);
        setM0(1'b1, 1'b0, 4'h0, 16'h0010, 32'd0);
        setM1(1'b1, 1'b0, 4'h0, 16'h0030, 32'd0);
        applyStimulus(2, 1'b1, 32'h3030_3030);
        applyStimulus(1, 1'b1, 32'h0000_0013);
        setM1(1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);

        // Reset right after a port-0 grant drops that response entirely.
        applyStimulus(1, 1'b0, 32'd0);
        setM0(1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);
        reset_n = 1'b0;
        repeat (2) applyStimulus(0, 1'b0, 32'd0);
        reset_n = 1'b1;
        setM0(1'b1, 1'b0, 4'h0, 16'h0020, 32'd0);
        applyStimulus(1, 1'b1, 32'hA5A5_0020);
        setM0(1'b0, 1'b0, 4'h0, 16'h0000, 32'd0);
        repeat (3) applyStimulus(0, 1'b0, 32'd0);

        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
